// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer
//  Purpose  : Parallel-to-serial converter (MSB first) with a valid/ready load
//             handshake, a one-word holding buffer for gapless streaming and a
//             programmable clocks-per-bit divider.
//  Revision : 1.0  initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             ser_out,
    output logic             bit_valid,
    output logic             done
);

    // Counter widths; a divide-by-one still keeps a 1-bit counter that
    // simply never leaves zero.
    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_BIT_W = $clog2(WIDTH);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_cnt_nxt;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   w_hold_nxt;
    logic               r_hold_valid;
    logic               w_hold_valid_nxt;

    logic               w_accept;
    logic               w_div_last;
    logic               w_bit_last;
    logic               w_end_of_word;

    // The producer may load whenever the holding buffer is empty; the shift
    // register itself never back-pressures because the buffer absorbs one word.
    assign ready         = !r_hold_valid && !reset;
    assign w_accept      = load && ready;
    assign w_div_last    = (r_div_cnt == c_DIV_LAST);
    assign w_bit_last    = (r_bit_cnt == c_BIT_LAST);
    assign w_end_of_word = (r_state == ST_SHIFT) && w_div_last && w_bit_last;

    // Output decode from registered state only (no path from load/data_in).
    always_comb begin
        ser_out   = 1'b0;
        bit_valid = 1'b0;
        done      = 1'b0;
        if (r_state == ST_SHIFT) begin
            ser_out   = r_shreg[WIDTH-1];
            bit_valid = w_div_last;
            done      = w_div_last && w_bit_last;
        end
    end

    // Next-state and datapath update for the shift engine and holding buffer.
    always_comb begin
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_div_cnt_nxt    = r_div_cnt;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;

        case (r_state)
            ST_IDLE: begin
                // Loads while idle go straight into the shift register.
                if (w_accept) begin
                    w_shreg_nxt   = data_in;
                    w_bit_cnt_nxt = '0;
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_div_last) begin
                    w_div_cnt_nxt = '0;
                    if (w_bit_last) begin
                        // Word boundary: held word wins, then a same-cycle
                        // load, otherwise the engine goes idle.
                        w_bit_cnt_nxt = '0;
                        if (r_hold_valid) begin
                            w_shreg_nxt      = r_hold;
                            w_hold_valid_nxt = 1'b0;
                        end else if (w_accept) begin
                            w_shreg_nxt = data_in;
                        end else begin
                            w_shreg_nxt = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_shreg_nxt   = {r_shreg[WIDTH-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end

                // Mid-word loads park in the holding buffer; an end-of-word
                // load was already consumed directly above.
                if (w_accept && !w_end_of_word) begin
                    w_hold_nxt       = data_in;
                    w_hold_valid_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: shift register, counters and holding buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer
//  Purpose  : Self-checking bench for bit_serializer: directed word sequences
//             followed by randomized load/reset traffic, checked against a
//             word-level timeline model and a bit scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

    localparam int WIDTH = 8;
    localparam int DIV   = 3;
    localparam int c_WORD_CYC = WIDTH * DIV;

    logic             clk = 1'b0;
    logic             r_reset;
    logic             r_load;
    logic [WIDTH-1:0] r_data;
    logic             w_ready;
    logic             w_ser;
    logic             w_bv;
    logic             w_done;

    bit_serializer #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
        .clk       (clk),
        .reset     (r_reset),
        .data_in   (r_data),
        .load      (r_load),
        .ready     (w_ready),
        .ser_out   (w_ser),
        .bit_valid (w_bv),
        .done      (w_done)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: {expected serial bit, expected done flag}.
    logic [1:0] sb[$];

    // Word-level timeline model: the active word, cycles left in it, and the
    // one-word waiting slot.
    int               m_rem;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_hold;
    logic             m_hv;

    int  n_tests;
    int  n_fail;
    bit  chk;

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every accepted word produces WIDTH bit events, MSB first, done on last.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sb.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic model_edge(input logic l, input logic [WIDTH-1:0] d, input logic r);
        logic acc;
        if (r) begin
            m_rem = 0;
            m_hv  = 1'b0;
            sb.delete();
            return;
        end
        acc = l && !m_hv;
        if (acc) push_word(d);
        if (m_rem > 0) m_rem--;
        if (m_rem == 0) begin
            if (m_hv) begin
                m_word = m_hold;
                m_hv   = 1'b0;
                m_rem  = c_WORD_CYC;
            end else if (acc) begin
                m_word = d;
                m_rem  = c_WORD_CYC;
            end
        end else if (acc) begin
            m_hold = d;
            m_hv   = 1'b1;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic cycle(input logic l, input logic [WIDTH-1:0] d, input logic r);
        r_load  = l;
        r_data  = d;
        r_reset = r;
        @(posedge clk);
        model_edge(l, d, r);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    // Monitor: per-cycle timing checks plus scoreboard pops on bit_valid.
    always @(negedge clk) begin
        int   e;
        logic e_ser;
        logic e_bv;
        logic [1:0] ent;
        if (chk) begin
            e     = c_WORD_CYC - m_rem;
            e_ser = (m_rem > 0) ? m_word[WIDTH - 1 - (e / DIV)] : 1'b0;
            e_bv  = (m_rem > 0) && ((e % DIV) == DIV - 1);
            check("ready", w_ready, !m_hv && !r_reset);
            check("ser_out", w_ser, e_ser);
            check("bit_valid", w_bv, e_bv);
            if (w_bv) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow at %0t: got bit_valid with no expected bit", $time);
                end else begin
                    ent = sb.pop_front();
                    check("sb_bit", w_ser, ent[1]);
                    check("sb_done", w_done, ent[0]);
                end
            end else begin
                check("done_idle", w_done, 1'b0);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk     = 1'b0;
        m_rem   = 0;
        m_hv    = 1'b0;
        m_word  = '0;
        m_hold  = '0;
        r_load  = 1'b0;
        r_data  = '0;
        r_reset = 1'b1;

        cycle(1'b0, '0, 1'b1);
        chk = 1'b1;
        cycle(1'b0, '0, 1'b1);
        idle(10);

        // Single word.
        cycle(1'b1, 8'hAA, 1'b0);
        idle(c_WORD_CYC + 2);

        // Back-to-back via the holding buffer.
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        idle(2 * c_WORD_CYC + 2);

        // Load exactly on the last edge of the current word.
        cycle(1'b1, 8'hF0, 1'b0);
        idle(c_WORD_CYC - 1);
        cycle(1'b1, 8'h0F, 1'b0);
        idle(c_WORD_CYC + 2);

        cycle(1'b1, 8'hC3, 1'b0);
        idle(c_WORD_CYC + 2);

        // Reset mid-word with a held word, then a clean reload.
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, 8'h81, 1'b0);
        idle(2);
        cycle(1'b0, '0, 1'b1);
        idle(3);
        cycle(1'b1, 8'h81, 1'b0);
        idle(c_WORD_CYC + 2);

        // Randomized traffic: loads are offered often, resets rarely.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 2) != 0), WIDTH'($urandom), ($urandom_range(0, 299) == 0));
        end
        idle(2 * c_WORD_CYC + 4);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected bits never appeared, required 0", sb.size());
        end

        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
